// File: rtl/io_feeder_pkg.sv
// Shared types and constants for the byte feeder: FSM state encoding and gap-counter sizing.
package io_feeder_pkg;

    localparam int GAP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAPW = 2'd2
    } feeder_state_e;

    // Counter preload on leaving SEND; GAP=0 never enters GAPW so the value is irrelevant there.
    function automatic logic [GAP_W-1:0] gap_load(input int gap);
        return (gap > 0) ? GAP_W'(gap - 1) : '0;
    endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// Byte FIFO with power-of-two depth; level distinguishes full from empty since pointers wrap.
module io_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic                       ready,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [7:0]    mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          do_push;
    logic          do_pop;

    // ready depends on level only, so a same-cycle pop never frees a slot for a push at full.
    assign ready   = (level_reg != LW'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_push = push && ready;
    assign do_pop  = pop && !empty;
    assign level   = level_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_reg + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!srst && do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Head is read combinationally so the launch edge can capture it with one-cycle latency.
    assign head = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/io_byte_feeder.sv
// Byte feeder: FIFO plus IDLE/SEND/GAPW sender emitting one-cycle en strobes to a downstream consumer.
// Optional sent-byte counter output sent_cnt is enabled with `define IO_BYTE_FEEDER_STATS_EN.
module io_byte_feeder
    import io_feeder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GAP   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    input  logic                       fdbk,
    output logic                       en,
    output logic [7:0]                 data,
    output logic [$clog2(DEPTH):0]     level
`ifdef IO_BYTE_FEEDER_STATS_EN
    ,
    output logic [15:0]                sent_cnt
`endif
);

    localparam logic [GAP_W-1:0] GAP_LOAD = gap_load(GAP);

    generate
        if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("io_byte_feeder: DEPTH must be a power of two in 2..64");
        end
        if ((GAP < 0) || (GAP > 15)) begin : g_bad_gap
            $error("io_byte_feeder: GAP must be in 0..15");
        end
    endgenerate

    feeder_state_e    state_reg;
    feeder_state_e    state_next;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_next;
    logic             en_reg;
    logic             en_next;
    logic [7:0]       data_reg;
    logic [7:0]       data_next;
    logic             pop;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             can_launch;

    io_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .head      (fifo_head),
        .ready     (in_ready),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign can_launch = !fifo_empty && !fdbk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= '0;
            en_reg      <= 1'b0;
            data_reg    <= 8'h00;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            en_reg      <= en_next;
            data_reg    <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (can_launch) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (GAP == 0) begin
                    state_next = can_launch ? SEND : IDLE;
                end else begin
                    state_next = GAPW;
                end
            end
            GAPW: begin
                // fdbk deliberately not looked at here; the gap always runs to completion.
                if (gap_cnt_reg == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Every transition into SEND is a launch: pop the head and register it with the strobe.
    always_comb begin
        pop          = 1'b0;
        en_next      = 1'b0;
        data_next    = data_reg;
        gap_cnt_next = gap_cnt_reg;
        if (state_next == SEND) begin
            pop       = 1'b1;
            en_next   = 1'b1;
            data_next = fifo_head;
        end
        if ((state_reg == SEND) && (state_next == GAPW)) begin
            gap_cnt_next = GAP_LOAD;
        end else if ((state_reg == GAPW) && (gap_cnt_reg != '0)) begin
            gap_cnt_next = gap_cnt_reg - 1'b1;
        end
    end

    assign en   = en_reg;
    assign data = data_reg;

`ifdef IO_BYTE_FEEDER_STATS_EN
    logic [15:0] sent_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sent_cnt_reg <= 16'h0000;
        end else if (en_reg) begin
            sent_cnt_reg <= sent_cnt_reg + 16'd1;
        end
    end

    assign sent_cnt = sent_cnt_reg;
`endif

endmodule

// File: tb/tb_io_byte_feeder.sv
// Self-checking bench for io_byte_feeder: directed scenarios plus a randomized run against a queue model.
module tb_io_byte_feeder;

    localparam int DEPTH = 8;
    localparam int LW    = 4;
    localparam int G2    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, fdbk, in_ready, en;
    logic [7:0]    in_data, data;
    logic [LW-1:0] level;
    logic          g2_in_valid, g2_fdbk, g2_in_ready, g2_en;
    logic [7:0]    g2_in_data, g2_data;
    logic [LW-1:0] g2_level;
`ifdef IO_BYTE_FEEDER_STATS_EN
    logic [15:0]   sent_cnt, g2_sent_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    io_byte_feeder #(.DEPTH(DEPTH), .GAP(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fdbk(fdbk), .en(en), .data(data), .level(level)
`ifdef IO_BYTE_FEEDER_STATS_EN
        , .sent_cnt(sent_cnt)
`endif
    );

    io_byte_feeder #(.DEPTH(DEPTH), .GAP(G2)) dut_g2 (
        .clk(clk), .rst(rst), .in_valid(g2_in_valid), .in_data(g2_in_data), .in_ready(g2_in_ready),
        .fdbk(g2_fdbk), .en(g2_en), .data(g2_data), .level(g2_level)
`ifdef IO_BYTE_FEEDER_STATS_EN
        , .sent_cnt(g2_sent_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; g2_in_valid = 1'b1; g2_in_data = 8'hEE;
        tick(); tick();
        vectors++; if (en !== 1'b0) begin miscompares++; $display("FAIL reset_en: got %b want 0", en); end
        vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data); end
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        vectors++; if (g2_en !== 1'b0) begin miscompares++; $display("FAIL reset_g2_en: got %b want 0", g2_en); end
        vectors++; if (g2_level !== 4'd0) begin miscompares++; $display("FAIL reset_g2_level: got %0d want 0", g2_level); end
`ifdef IO_BYTE_FEEDER_STATS_EN
        vectors++; if (sent_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_sent_cnt: got %0d want 0", sent_cnt); end
`endif
        rst = 1'b0; in_valid = 1'b0; g2_in_valid = 1'b0;
        tick();
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL reset_push_ignored: level %0d want 0", level); end
        vectors++; if (en !== 1'b0) begin miscompares++; $display("FAIL reset_no_en: got %b want 0", en); end
        $display("reset: done");
    endtask

    task automatic test_single();
        fdbk = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        vectors++; if (level !== 4'd1) begin miscompares++; $display("FAIL single_level1: got %0d want 1", level); end
        vectors++; if (en !== 1'b0) begin miscompares++; $display("FAIL single_early_en: got %b want 0", en); end
        tick();
        vectors++; if (en !== 1'b1) begin miscompares++; $display("FAIL single_en: got %b want 1", en); end
        vectors++; if (data !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h want a5", data); end
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL single_level0: got %0d want 0", level); end
        tick();
        vectors++; if (en !== 1'b0) begin miscompares++; $display("FAIL single_one_pulse: got %b want 0", en); end
        vectors++; if (data !== 8'hA5) begin miscompares++; $display("FAIL single_hold: got %h want a5", data); end
        $display("single: sent a5");
    endtask

    task automatic test_burst_gap0();
        fdbk = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
            vectors++; if (level !== 4'(i)) begin miscompares++; $display("FAIL burst_fill_level: got %0d want %0d", level, i); end
            vectors++; if (in_ready !== (i != 8)) begin miscompares++; $display("FAIL burst_ready: got %b at level %0d", in_ready, i); end
        end
        in_valid = 1'b0; fdbk = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            vectors++; if (en !== 1'b1) begin miscompares++; $display("FAIL burst_en: got %b want 1 (byte %0d)", en, j); end
            vectors++; if (data !== 8'(j)) begin miscompares++; $display("FAIL burst_data: got %h want %h", data, 8'(j)); end
            vectors++; if (level !== 4'(8 - j)) begin miscompares++; $display("FAIL burst_level: got %0d want %0d", level, 8 - j); end
        end
        tick();
        vectors++; if (en !== 1'b0) begin miscompares++; $display("FAIL burst_end_en: got %b want 0", en); end
        $display("burst_gap0: 8 bytes");
    endtask

    task automatic test_burst_gap2();
        logic [7:0] last;
        bit         exp_en;
        int         k;
        last = 8'h00; g2_fdbk = 1'b0;
        for (int t = 0; t < 14; t++) begin
            g2_in_valid = (t < 3); g2_in_data = 8'h10 + 8'(t);
            tick();
            // First byte launches one edge after its push, then every GAP + 2 cycles.
            exp_en = (t >= 1) && (((t - 1) % (G2 + 2)) == 0) && (((t - 1) / (G2 + 2)) < 3);
            if (exp_en) begin
                k = (t - 1) / (G2 + 2);
                last = 8'h10 + 8'(k);
            end
            vectors++; if (g2_en !== exp_en) begin miscompares++; $display("FAIL gap2_en: t=%0d got %b want %b", t, g2_en, exp_en); end
            vectors++; if (g2_data !== last) begin miscompares++; $display("FAIL gap2_data: t=%0d got %h want %h", t, g2_data, last); end
        end
        g2_in_valid = 1'b0;
        vectors++; if (g2_level !== 4'd0) begin miscompares++; $display("FAIL gap2_level: got %0d want 0", g2_level); end
        $display("burst_gap2: 3 bytes");
    endtask

    task automatic test_backpressure();
        logic [7:0] b [3];
        fdbk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b[i] = 8'($urandom); in_valid = 1'b1; in_data = b[i];
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++; if (en !== 1'b0) begin miscompares++; $display("FAIL bp_hold_en: cycle %0d got %b want 0", c, en); end
            vectors++; if (level !== 4'd3) begin miscompares++; $display("FAIL bp_hold_level: got %0d want 3", level); end
        end
        fdbk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (en !== 1'b1) begin miscompares++; $display("FAIL bp_release_en: got %b want 1", en); end
            vectors++; if (data !== b[i]) begin miscompares++; $display("FAIL bp_release_data: got %h want %h", data, b[i]); end
        end
        tick();
        // Raise fdbk while a byte is in SEND: that byte stays sent, the next waits.
        fdbk = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b[i] = 8'($urandom); in_valid = 1'b1; in_data = b[i];
            tick();
        end
        in_valid = 1'b0; fdbk = 1'b0;
        tick();
        vectors++; if ((en !== 1'b1) || (data !== b[0])) begin miscompares++; $display("FAIL bp_send: en %b data %h want 1 %h", en, data, b[0]); end
        fdbk = 1'b1;
        tick();
        vectors++; if (en !== 1'b0) begin miscompares++; $display("FAIL bp_mid_en: got %b want 0", en); end
        vectors++; if (data !== b[0]) begin miscompares++; $display("FAIL bp_mid_data: got %h want %h", data, b[0]); end
        vectors++; if (level !== 4'd1) begin miscompares++; $display("FAIL bp_mid_level: got %0d want 1", level); end
        fdbk = 1'b0;
        tick();
        vectors++; if ((en !== 1'b1) || (data !== b[1])) begin miscompares++; $display("FAIL bp_resume: en %b data %h want 1 %h", en, data, b[1]); end
        tick();
        $display("backpressure: done");
    endtask

    task automatic test_full_reset();
        logic [7:0] b [9];
        fdbk = 1'b1;
        for (int i = 0; i < 9; i++) begin
            b[i] = 8'($urandom); in_valid = 1'b1; in_data = b[i];
            vectors++; if (in_ready !== (i < 8)) begin miscompares++; $display("FAIL full_ready: push %0d got %b", i + 1, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        vectors++; if (level !== 4'd8) begin miscompares++; $display("FAIL full_level: got %0d want 8", level); end
        fdbk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if ((en !== 1'b1) || (data !== b[i])) begin miscompares++; $display("FAIL full_drain: en %b data %h want 1 %h", en, data, b[i]); end
        end
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        tick();
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL midrst_level: got %0d want 0", level); end
        vectors++; if (en !== 1'b0) begin miscompares++; $display("FAIL midrst_en: got %b want 0", en); end
        vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL midrst_data: got %h want 00", data); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        vectors++; if ((en !== 1'b0) || (level !== 4'd0)) begin miscompares++; $display("FAIL midrst_after: en %b level %0d want 0 0", en, level); end
        $display("full_reset: done");
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] last;
        bit         will_push, will_send;
        int         pfb;
        rst = 1'b1; tick(); rst = 1'b0;
        last = 8'h00;
        for (int c = 0; c < 400; c++) begin
            pfb = (c < 200) ? 7 : 2;
            in_valid = ($urandom_range(0, 9) < 6);
            in_data  = 8'($urandom);
            fdbk     = ($urandom_range(0, 9) < pfb);
            rst      = ($urandom_range(0, 99) == 0);
            will_push = in_valid && !rst && (q.size() != DEPTH);
            will_send = !rst && (q.size() > 0) && !fdbk;
            tick();
            if (rst) begin
                q.delete();
                last = 8'h00;
                will_send = 1'b0;
            end else begin
                if (will_send) last = q.pop_front();
                if (will_push) q.push_back(in_data);
            end
            vectors++; if (en !== will_send) begin miscompares++; $display("FAIL rnd_en: cycle %0d got %b want %b", c, en, will_send); end
            vectors++; if (data !== last) begin miscompares++; $display("FAIL rnd_data: cycle %0d got %h want %h", c, data, last); end
            vectors++; if (level !== 4'(q.size())) begin miscompares++; $display("FAIL rnd_level: cycle %0d got %0d want %0d", c, level, q.size()); end
            vectors++; if (in_ready !== (q.size() != DEPTH)) begin miscompares++; $display("FAIL rnd_ready: cycle %0d got %b", c, in_ready); end
        end
        rst = 1'b0; in_valid = 1'b0; fdbk = 1'b0;
        $display("random: 400 cycles");
    endtask

`ifdef IO_BYTE_FEEDER_STATS_EN
    task automatic test_stats_wrap();
        int          pushed, sent, cycles;
        logic [15:0] model_cnt;
        bit          will_push;
        rst = 1'b1; tick(); rst = 1'b0;
        pushed = 0; sent = 0; cycles = 0; model_cnt = 16'd0; fdbk = 1'b0;
        vectors++; if (sent_cnt !== 16'd0) begin miscompares++; $display("FAIL stats_reset: got %0d want 0", sent_cnt); end
        while ((sent < 65537) && (cycles < 70000)) begin
            in_valid  = (pushed < 65537);
            in_data   = 8'($urandom);
            will_push = in_valid && in_ready;
            tick();
            cycles++;
            if (will_push) pushed++;
            if (en) begin sent++; model_cnt = model_cnt + 16'd1; end
        end
        in_valid = 1'b0;
        vectors++; if (sent != 65537) begin miscompares++; $display("FAIL stats_timeout: sent %0d want 65537", sent); end
        tick();
        vectors++; if (sent_cnt !== model_cnt) begin miscompares++; $display("FAIL stats_cnt: got %0d want %0d", sent_cnt, model_cnt); end
        vectors++; if (sent_cnt !== 16'd1) begin miscompares++; $display("FAIL stats_wrap: got %0d want 1", sent_cnt); end
        $display("stats_wrap: %0d bytes", sent);
    endtask
`endif

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; fdbk = 1'b0;
        g2_in_valid = 1'b0; g2_in_data = 8'h00; g2_fdbk = 1'b0;
        test_reset();
        test_single();
        test_burst_gap0();
        test_burst_gap2();
        test_backpressure();
        test_full_reset();
        test_random();
`ifdef IO_BYTE_FEEDER_STATS_EN
        test_stats_wrap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_byte_feeder.md
IO_BYTE_FEEDER -- requirements
Module: io_byte_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO depth in bytes (power of two, 2..64).
REQ-002 The block SHALL have parameter GAP, default 0, meaning minimum idle cycles between consecutive en pulses (0..15).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the upstream byte is valid.
REQ-006 The block SHALL have port in_data, input, 8, meaning the upstream byte.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the FIFO can accept a byte.
REQ-008 The block SHALL have port fdbk, input, 1, meaning downstream busy; high pauses sending.
REQ-009 The block SHALL have port en, output, 1, meaning a one-cycle strobe qualifying data, driven to the downstream consumer's en.
REQ-010 The block SHALL have port data, output, 8, meaning the byte presented downstream.
REQ-011 The block SHALL have port level, output, $clog2(DEPTH)+1, meaning FIFO occupancy.

Function
REQ-012 Push SHALL occur on any edge where in_valid && in_ready; in_ready SHALL be (level != DEPTH), combinational from level only.
REQ-013 At full, push SHALL be refused even if a pop occurs in the same cycle; in_data is ignored whenever in_ready is low.
REQ-014 Simultaneous push and pop when not full SHALL leave level unchanged, with FIFO order preserved.
REQ-015 The FSM SHALL have the states IDLE, SEND and GAPW.
REQ-016 IDLE SHALL go to SEND when the FIFO is non-empty and fdbk is low; that same edge SHALL load data with the FIFO head and pop it. Otherwise the FSM SHALL stay in IDLE.
REQ-017 In SEND, en SHALL be 1 for exactly one cycle. On exit:
- GAP=0: go to SEND if non-empty and fdbk is low (back-to-back bytes), else go to IDLE.
- GAP>0: go to GAPW with the counter loaded to GAP-1.
REQ-018 GAPW SHALL hold en low and decrement the counter; at 0 it SHALL go to IDLE.
REQ-019 fdbk rising during SEND SHALL NOT abort or repeat the current byte; fdbk is ignored in GAPW.
REQ-020 Latency: a byte pushed at edge k into an empty FIFO, with the FSM in IDLE and fdbk low, SHALL produce en=1 in the cycle after edge k+1.
REQ-021 data SHALL hold the last sent byte while en is low.
REQ-022 en and data SHALL be registered outputs.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH, with level distinguishing full from empty.

Reset
REQ-024 On rst high at an edge, the block SHALL set state to IDLE, en to 0, data to 8'h00, level to 0, pointers to 0 and the gap counter to 0.
REQ-025 Reset mid-operation SHALL discard all buffered bytes and any byte in SEND; no en pulse SHALL occur in the cycle after reset.
REQ-026 Pushes presented while rst is high SHALL be ignored.

Configuration
REQ-027 With IO_BYTE_FEEDER_STATS_EN defined, the block SHALL add output sent_cnt[15:0], reset to 0, incrementing once per en=1 cycle and wrapping 16'hFFFF->16'h0000.
REQ-028 Without IO_BYTE_FEEDER_STATS_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package io_feeder_pkg SHALL hold the FSM state enum (IDLE, SEND, GAPW) and constant GAP_W=4.
REQ-030 FIFO storage, pointers and level SHALL live in sub-module io_byte_fifo; FSM and output registers SHALL live in io_byte_feeder.

Verification
REQ-031 Single byte: push 8'hA5 into an empty FIFO, fdbk=0 -> one en pulse with data=8'hA5, two cycles after the push edge; level returns to 0.
REQ-032 Burst, GAP=0: push 8'h01..8'h08 -> eight consecutive en cycles with data 01..08 in order; in_ready low only while level=8.
REQ-033 Burst, GAP=2: push 8'h10,8'h11,8'h12 -> en pulses separated by exactly 2 idle cycles after SEND plus one IDLE cycle.
REQ-034 Backpressure: hold fdbk=1 for 10 cycles with 3 bytes queued -> no en, level=3; on fdbk release the bytes are sent in order; fdbk raised during SEND does not drop that byte.
REQ-035 Full: push 9 bytes with fdbk=1 -> 9th refused (in_ready=0, level=8); rst mid-burst -> level=0, en=0, data=8'h00 next cycle.
REQ-036 STATS_EN: send 65537 bytes -> sent_cnt=1 (wrap checked).
